// File: rtl/retospect_cfg_pkg.sv
// Shared types and constants for the neurochip configuration loader.
// CRC-16-CCITT helper is bit-serial, MSB-first.
package retospect_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READBACK,
    ARM,
    DONE
  } loader_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  localparam int CNB_BITS      = 19;
  localparam int CLOCKBOX_BITS = 48;

  function automatic logic [15:0] crc16_step(
    input logic [15:0] crc,
    input logic        b
  );
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/retospect_crc16_serial.sv
// Bit-serial CRC-16 accumulator with synchronous clear.
// One instance tracks loaded bits, another tracks readback bits.
module retospect_crc16_serial
  import retospect_cfg_pkg::*;
#(
  parameter logic [15:0] INIT = CRC16_INIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_crc <= INIT;
    end else if (i_en) begin
      r_crc <= crc16_step(r_crc, i_bit);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/retospect_bitstream_loader.sv
// Serialises a byte stream into the neurochip config chain, optionally
// rotates it back out for a CRC check, then pulses reset_nn to arm it.
module retospect_bitstream_loader
  import retospect_cfg_pkg::*;
#(
  parameter int          CHAIN_LEN = CLOCKBOX_BITS + 70 * CNB_BITS,
  parameter int          CNT_W     = 11,
  parameter logic [15:0] CRC_INIT  = CRC16_INIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        verify_en,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        cfg_config_en,
  output logic        cfg_bs_in,
  input  logic        cfg_bs_out,
  output logic        cfg_reset_nn,
  output logic        busy,
  output logic        done,
  output logic        crc_ok,
  output logic [15:0] crc_value
);

  localparam logic [CNT_W-1:0] LEN  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  loader_state_e    r_state;
  loader_state_e    w_next;
  logic [CNT_W-1:0] r_bitcnt;
  logic [CNT_W-1:0] r_rbcnt;
  logic [3:0]       r_nib;
  logic [7:0]       r_byte;
  logic             r_verify;
  logic             r_crc_ok;
  logic [15:0]      r_crc_value;
  logic             r_cfg_en;
  logic             r_bs_in;
  logic             r_reset_nn;
  logic             r_done;

  logic             w_shift;
  logic [CNT_W-1:0] w_cnt_after;
  logic [CNT_W-1:0] w_rem;
  logic             w_ready;
  logic             w_accept;
  logic [3:0]       w_nib_load;
  logic [3:0]       w_nib_next;
  logic [7:0]       w_byte_next;
  logic             w_cfg_en_next;
  logic [15:0]      w_crc_load;
  logic [15:0]      w_crc_rb;

  assign w_shift     = (r_state == LOAD) && (r_nib != 4'd0);
  assign w_cnt_after = r_bitcnt + CNT_W'(w_shift);
  assign w_rem       = LEN - w_cnt_after;
  // a new byte may land on the same edge the last bit of the old one leaves
  assign w_ready     = (r_state == LOAD) && (r_nib <= 4'd1)
                     && (w_cnt_after < LEN);
  assign w_accept    = w_ready && in_valid;
  assign w_nib_load  = (w_rem >= CNT_W'(8)) ? 4'd8 : w_rem[3:0];

  always_comb begin
    w_next      = r_state;
    w_nib_next  = r_nib;
    w_byte_next = r_byte;
    if (w_accept) begin
      w_nib_next  = w_nib_load;
      w_byte_next = in_data;
    end else if (w_shift) begin
      w_nib_next  = r_nib - 4'd1;
      w_byte_next = {1'b0, r_byte[7:1]};
    end
    unique case (r_state)
      IDLE: begin
        w_nib_next = 4'd0;
        if (start) w_next = LOAD;
      end
      LOAD: begin
        if (w_shift && r_bitcnt == LAST)
          w_next = r_verify ? READBACK : ARM;
      end
      READBACK: begin
        if (r_rbcnt == LAST) w_next = ARM;
      end
      ARM:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // chain-facing strobes are flops loaded from next-cycle state
  assign w_cfg_en_next = ((w_next == LOAD) && (w_nib_next != 4'd0))
                       || (w_next == READBACK);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bitcnt    <= '0;
      r_rbcnt     <= '0;
      r_nib       <= '0;
      r_byte      <= '0;
      r_verify    <= 1'b0;
      r_crc_ok    <= 1'b0;
      r_crc_value <= '0;
      r_cfg_en    <= 1'b0;
      r_bs_in     <= 1'b0;
      r_reset_nn  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_nib      <= w_nib_next;
      r_byte     <= w_byte_next;
      r_cfg_en   <= w_cfg_en_next;
      r_bs_in    <= w_cfg_en_next & w_byte_next[0];
      r_reset_nn <= (w_next == ARM);
      r_done     <= (w_next == DONE);
      if (r_state == IDLE) begin
        r_bitcnt <= '0;
      end else if (w_shift) begin
        r_bitcnt <= w_cnt_after;
      end
      if (r_state == READBACK) begin
        r_rbcnt <= r_rbcnt + CNT_W'(1);
      end else begin
        r_rbcnt <= '0;
      end
      if (r_state == IDLE && start) begin
        r_verify <= verify_en;
        r_crc_ok <= 1'b0;
      end
      if (r_state == ARM) begin
        r_crc_value <= w_crc_load;
        if (r_verify) r_crc_ok <= (w_crc_rb == w_crc_load);
      end
    end
  end

  retospect_crc16_serial #(.INIT(CRC_INIT)) u_crc_load (
    .clk     (clk),
    .reset   (reset),
    .i_clear (r_state == IDLE),
    .i_en    (w_shift),
    .i_bit   (r_byte[0]),
    .o_crc   (w_crc_load)
  );

  retospect_crc16_serial #(.INIT(CRC_INIT)) u_crc_rb (
    .clk     (clk),
    .reset   (reset),
    .i_clear (r_state == IDLE),
    .i_en    (r_state == READBACK),
    .i_bit   (cfg_bs_out),
    .o_crc   (w_crc_rb)
  );

  assign in_ready      = w_ready;
  assign cfg_config_en = r_cfg_en;
  // readback rotates the chain through a combinational bypass
  assign cfg_bs_in     = (r_state == READBACK) ? cfg_bs_out : r_bs_in;
  assign cfg_reset_nn  = r_reset_nn;
  assign busy          = (r_state != IDLE);
  assign done          = r_done;
  assign crc_ok        = r_crc_ok;
  assign crc_value     = r_crc_value;

endmodule

// File: tb/tb_retospect_bitstream_loader.sv
// Directed bench: a one-cnb chain (19 bits) and the full 1378-bit chain,
// each driving a behavioural rotating shift-register chain model.
module tb_retospect_bitstream_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- small instance (CHAIN_LEN = 19) ----------------
  logic        s_start = 0, s_ver = 0, s_valid = 0;
  logic [7:0]  s_data;
  logic        s_ready, s_en, s_bsin, s_bsout, s_rnn;
  logic        s_busy, s_done, s_ok;
  logic [15:0] s_crc;
  logic        s_flip = 0;
  int          s_base = 0, s_abase = 0;
  int          s_en_cnt = 0, s_acc = 0, s_rnn_cnt = 0;
  int          s_done_cnt = 0, s_viol = 0;
  logic [18:0] s_chain = '0;
  logic [18:0] s_got = '0;
  logic [18:0] s_snap = '0;
  logic [7:0]  s_mem [0:2];

  assign s_data  = (s_acc - s_abase < 3) ? s_mem[s_acc - s_abase] : 8'hEE;
  assign s_bsout = s_chain[18] ^ (s_flip && (s_en_cnt - s_base == 26));

  retospect_bitstream_loader #(.CHAIN_LEN(19), .CNT_W(5)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .verify_en(s_ver),
    .in_valid(s_valid), .in_data(s_data), .in_ready(s_ready),
    .cfg_config_en(s_en), .cfg_bs_in(s_bsin), .cfg_bs_out(s_bsout),
    .cfg_reset_nn(s_rnn), .busy(s_busy), .done(s_done),
    .crc_ok(s_ok), .crc_value(s_crc)
  );

  always @(posedge clk) begin
    if (s_en) begin
      s_en_cnt <= s_en_cnt + 1;
      if (s_en_cnt - s_base < 19) s_got[s_en_cnt - s_base] <= s_bsin;
      if (s_en_cnt - s_base == 18) s_snap <= {s_chain[17:0], s_bsin};
      s_chain <= {s_chain[17:0], s_bsin};
    end
    if (s_rnn) s_rnn_cnt <= s_rnn_cnt + 1;
    if (s_done) s_done_cnt <= s_done_cnt + 1;
    if (s_rnn && s_en) s_viol <= s_viol + 1;
    if (s_valid && s_ready) s_acc <= s_acc + 1;
  end

  // ---------------- large instance (default CHAIN_LEN) ----------------
  logic        l_start = 0, l_ver = 0, l_valid = 0;
  logic [7:0]  l_data;
  logic        l_ready, l_en, l_bsin, l_bsout, l_rnn;
  logic        l_busy, l_done, l_ok;
  logic [15:0] l_crc;
  int          l_base = 0, l_abase = 0;
  int          l_en_cnt = 0, l_acc = 0, l_rnn_cnt = 0;
  int          l_done_cnt = 0, l_viol = 0, l_err = 0;
  logic [1377:0] l_chain = '0;
  logic [7:0]  l_mem [0:172];

  assign l_data  = (l_acc - l_abase < 173) ? l_mem[l_acc - l_abase] : 8'h00;
  assign l_bsout = l_chain[1377];

  retospect_bitstream_loader u_large (
    .clk(clk), .reset(reset), .start(l_start), .verify_en(l_ver),
    .in_valid(l_valid), .in_data(l_data), .in_ready(l_ready),
    .cfg_config_en(l_en), .cfg_bs_in(l_bsin), .cfg_bs_out(l_bsout),
    .cfg_reset_nn(l_rnn), .busy(l_busy), .done(l_done),
    .crc_ok(l_ok), .crc_value(l_crc)
  );

  always @(posedge clk) begin
    if (l_en) begin
      l_en_cnt <= l_en_cnt + 1;
      if (l_en_cnt - l_base < 1378 &&
          l_bsin !== l_mem[(l_en_cnt - l_base) / 8][(l_en_cnt - l_base) % 8])
        l_err <= l_err + 1;
      l_chain <= {l_chain[1376:0], l_bsin};
    end
    if (l_rnn) l_rnn_cnt <= l_rnn_cnt + 1;
    if (l_done) l_done_cnt <= l_done_cnt + 1;
    if (l_rnn && l_en) l_viol <= l_viol + 1;
    if (l_valid && l_ready) l_acc <= l_acc + 1;
  end

  // ---------------- reference CRC ----------------
  function automatic logic [15:0] m_step(input logic [15:0] c, input logic b);
    logic [15:0] n;
    n = {c[14:0], 1'b0};
    if (c[15] ^ b) n = n ^ 16'h1021;
    return n;
  endfunction

  function automatic logic [15:0] m_crc_small(input logic [18:0] v);
    logic [15:0] c = 16'hFFFF;
    for (int k = 0; k < 19; k++) c = m_step(c, v[k]);
    return c;
  endfunction

  function automatic logic [15:0] m_crc_large();
    logic [15:0] c = 16'hFFFF;
    for (int k = 0; k < 1378; k++) c = m_step(c, l_mem[k / 8][k % 8]);
    return c;
  endfunction

  // LSB-first bits of A5, 3C and the low three bits of 05
  localparam logic [18:0] S_BITS = 19'h53CA5;

  // ---------------- small-chain driver ----------------
  task automatic run_small(input logic ver, input logic flip,
                           input int pulse_at, output int lat);
    @(negedge clk);
    s_base  = s_en_cnt;
    s_abase = s_acc;
    s_flip  = flip;
    s_ver   = ver;
    s_valid = 1'b1;
    s_start = 1'b1;
    @(negedge clk);
    lat = 1;
    s_start = (lat == pulse_at);
    while (s_done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
      s_start = (lat == pulse_at);
    end
    s_start = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_busy, s_ready, s_en, s_rnn, s_done, s_ok} !== 6'b0) begin
      failures++;
      $display("FAIL reset_small_ctl got=%b want=000000",
               {s_busy, s_ready, s_en, s_rnn, s_done, s_ok});
    end
    checks++;
    if (s_crc !== 16'h0000) begin
      failures++;
      $display("FAIL reset_small_crc got=%h want=0000", s_crc);
    end
    checks++;
    if ({l_busy, l_ready, l_en, l_rnn, l_done, l_ok} !== 6'b0) begin
      failures++;
      $display("FAIL reset_large_ctl got=%b want=000000",
               {l_busy, l_ready, l_en, l_rnn, l_done, l_ok});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_noverify();
    int lat, en0, r0, d0, a0;
    en0 = s_en_cnt; r0 = s_rnn_cnt; d0 = s_done_cnt; a0 = s_acc;
    run_small(1'b0, 1'b0, 0, lat);
    checks++;
    if (lat !== 22) begin
      failures++;
      $display("FAIL load_latency got=%0d want=22", lat);
    end
    checks++;
    if (s_en_cnt - en0 !== 19) begin
      failures++;
      $display("FAIL load_en_cycles got=%0d want=19", s_en_cnt - en0);
    end
    checks++;
    if (s_got !== S_BITS) begin
      failures++;
      $display("FAIL load_bits got=%h want=%h", s_got, S_BITS);
    end
    checks++;
    if (s_acc - a0 !== 3) begin
      failures++;
      $display("FAIL load_bytes got=%0d want=3", s_acc - a0);
    end
    checks++;
    if (s_rnn_cnt - r0 !== 1 || s_done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL load_pulses rnn=%0d done=%0d want=1,1",
               s_rnn_cnt - r0, s_done_cnt - d0);
    end
    checks++;
    if (s_crc !== m_crc_small(S_BITS)) begin
      failures++;
      $display("FAIL load_crc got=%h want=%h", s_crc, m_crc_small(S_BITS));
    end
    checks++;
    if (s_busy !== 1'b0 || s_ok !== 1'b0) begin
      failures++;
      $display("FAIL load_idle busy=%b ok=%b want=0,0", s_busy, s_ok);
    end
  endtask

  task automatic test_verify();
    int lat, en0;
    logic [18:0] exp_chain;
    for (int k = 0; k < 19; k++) exp_chain[18 - k] = S_BITS[k];
    en0 = s_en_cnt;
    run_small(1'b1, 1'b0, 0, lat);
    checks++;
    if (lat !== 41) begin
      failures++;
      $display("FAIL verify_latency got=%0d want=41", lat);
    end
    checks++;
    if (s_en_cnt - en0 !== 38) begin
      failures++;
      $display("FAIL verify_en_cycles got=%0d want=38", s_en_cnt - en0);
    end
    checks++;
    if (s_ok !== 1'b1) begin
      failures++;
      $display("FAIL verify_crc_ok got=%b want=1", s_ok);
    end
    checks++;
    if (s_snap !== exp_chain) begin
      failures++;
      $display("FAIL verify_loaded got=%h want=%h", s_snap, exp_chain);
    end
    checks++;
    if (s_chain !== exp_chain) begin
      failures++;
      $display("FAIL verify_restored got=%h want=%h", s_chain, exp_chain);
    end
    checks++;
    if (s_crc !== m_crc_small(S_BITS)) begin
      failures++;
      $display("FAIL verify_crc got=%h want=%h", s_crc, m_crc_small(S_BITS));
    end
  endtask

  task automatic test_verify_flip();
    int lat, r0, d0;
    r0 = s_rnn_cnt; d0 = s_done_cnt;
    run_small(1'b1, 1'b1, 0, lat);
    s_flip = 1'b0;
    checks++;
    if (s_ok !== 1'b0) begin
      failures++;
      $display("FAIL flip_crc_ok got=%b want=0", s_ok);
    end
    checks++;
    if (lat !== 41 || s_done_cnt - d0 !== 1 || s_rnn_cnt - r0 !== 1) begin
      failures++;
      $display("FAIL flip_pulses lat=%0d done=%0d rnn=%0d want=41,1,1",
               lat, s_done_cnt - d0, s_rnn_cnt - r0);
    end
  endtask

  task automatic test_start_busy();
    int lat, en0, d0;
    en0 = s_en_cnt; d0 = s_done_cnt;
    run_small(1'b0, 1'b0, 6, lat);
    repeat (5) @(negedge clk);
    checks++;
    if (lat !== 22 || s_en_cnt - en0 !== 19) begin
      failures++;
      $display("FAIL busy_start lat=%0d en=%0d want=22,19",
               lat, s_en_cnt - en0);
    end
    checks++;
    if (s_done_cnt - d0 !== 1 || s_busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_done done=%0d busy=%b want=1,0",
               s_done_cnt - d0, s_busy);
    end
    checks++;
    if (s_viol !== 0) begin
      failures++;
      $display("FAIL small_invariant got=%0d want=0", s_viol);
    end
  endtask

  task automatic test_stall();
    int n, d0, r0, bad;
    d0 = l_done_cnt; r0 = l_rnn_cnt;
    @(negedge clk);
    l_base = l_en_cnt; l_abase = l_acc; l_err = l_err;
    l_ver = 1'b0; l_valid = 1'b1; l_start = 1'b1;
    @(negedge clk);
    l_start = 1'b0;
    n = 0;
    while (l_acc - l_abase < 11 && n < 200) begin
      @(negedge clk);
      n++;
    end
    l_valid = 1'b0;
    n = 0;
    while (l_en !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (l_en_cnt - l_base !== 88 || l_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_entry bits=%0d ready=%b want=88,1",
               l_en_cnt - l_base, l_ready);
    end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (l_en !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || l_en_cnt - l_base !== 88) begin
      failures++;
      $display("FAIL stall_hold en_high=%0d bits=%0d want=0,88",
               bad, l_en_cnt - l_base);
    end
    l_valid = 1'b1;
    n = 0;
    while (l_done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    l_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (l_done_cnt - d0 !== 1 || l_rnn_cnt - r0 !== 1) begin
      failures++;
      $display("FAIL stall_pulses done=%0d rnn=%0d want=1,1",
               l_done_cnt - d0, l_rnn_cnt - r0);
    end
    checks++;
    if (l_en_cnt - l_base !== 1378 || l_acc - l_abase !== 173) begin
      failures++;
      $display("FAIL stall_totals bits=%0d bytes=%0d want=1378,173",
               l_en_cnt - l_base, l_acc - l_abase);
    end
    checks++;
    if (l_err !== 0) begin
      failures++;
      $display("FAIL stall_bits errors=%0d want=0", l_err);
    end
    checks++;
    if (l_crc !== m_crc_large()) begin
      failures++;
      $display("FAIL stall_crc got=%h want=%h", l_crc, m_crc_large());
    end
  endtask

  task automatic test_reset_midload();
    int n, d0, r0, e0;
    d0 = l_done_cnt;
    @(negedge clk);
    l_base = l_en_cnt; l_abase = l_acc;
    l_valid = 1'b1; l_start = 1'b1;
    @(negedge clk);
    l_start = 1'b0;
    n = 0;
    while (l_en_cnt - l_base < 500 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({l_busy, l_ready, l_en, l_rnn, l_done} !== 5'b0) begin
      failures++;
      $display("FAIL midreset_ctl got=%b want=00000",
               {l_busy, l_ready, l_en, l_rnn, l_done});
    end
    repeat (20) @(negedge clk);
    checks++;
    if (l_done_cnt - d0 !== 0 || l_busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_nodone done=%0d busy=%b want=0,0",
               l_done_cnt - d0, l_busy);
    end
    e0 = l_err; r0 = l_rnn_cnt; d0 = l_done_cnt;
    l_base = l_en_cnt; l_abase = l_acc;
    l_start = 1'b1;
    @(negedge clk);
    l_start = 1'b0;
    n = 0;
    while (l_done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    l_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (l_en_cnt - l_base !== 1378 || l_err - e0 !== 0) begin
      failures++;
      $display("FAIL restart_bits bits=%0d errors=%0d want=1378,0",
               l_en_cnt - l_base, l_err - e0);
    end
    checks++;
    if (l_done_cnt - d0 !== 1 || l_rnn_cnt - r0 !== 1 ||
        l_crc !== m_crc_large()) begin
      failures++;
      $display("FAIL restart_end done=%0d rnn=%0d crc=%h want=1,1,%h",
               l_done_cnt - d0, l_rnn_cnt - r0, l_crc, m_crc_large());
    end
    checks++;
    if (l_viol !== 0) begin
      failures++;
      $display("FAIL large_invariant got=%0d want=0", l_viol);
    end
  endtask

  initial begin
    s_mem[0] = 8'hA5;
    s_mem[1] = 8'h3C;
    s_mem[2] = 8'h05;
    for (int i = 0; i < 173; i++) l_mem[i] = 8'(i * 37 + 11);
    test_reset();
    test_load_noverify();
    test_verify();
    test_verify_flip();
    test_start_busy();
    test_stall();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
